// File: rtl/poly_bram_unloader_pkg.sv
// Shared definitions for the result-BRAM unloader.
// Holds the parameter defaults, the controller state encoding and the read tag
// that travels alongside each outstanding BRAM read.
package poly_bram_unloader_pkg;

    localparam int unsigned LOGQ_DEF        = 54;
    localparam int unsigned LOGN_DEF        = 13;
    localparam int unsigned BRAM_RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } unload_state_e;

    // valid: a read was issued; sel: 0 = BRAM 0, 1 = BRAM 1; last: final word of the unload
    typedef struct packed {
        logic valid;
        logic sel;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/delay_register_reset.sv
// DelayRegisterReset: fixed-depth shift register with synchronous, active-high reset.
// Ports:
//   clk, rst  clock and synchronous reset (clears every stage)
//   d_i       input word
//   q_o       input word delayed by DEPTH clock edges
module DelayRegisterReset #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/poly_bram_unloader_fifo.sv
// unload_sync_fifo: small synchronous FIFO buffering unloaded coefficients.
// Ports:
//   clk, rst  clock and synchronous reset (empties the FIFO, clears storage)
//   push_i    write wdata_i this cycle
//   wdata_i   word to write
//   pop_i     drop the head word this cycle
//   rdata_o   head word (valid while !empty_o)
//   count_o   number of stored words
//   empty_o   no words stored
//   full_o    DEPTH words stored
module unload_sync_fifo #(
    parameter int unsigned WIDTH = 55,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    // Upstream credit accounting must make this impossible.
    push_while_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/poly_bram_unloader.sv
// poly_bram_unloader: streams the result polynomial(s) from the result BRAMs to the host.
// Ports:
//   clk, rst        clock and synchronous, active-high reset
//   start, both     begin an unload (sampled in IDLE); both=1 unloads poly0 then poly1
//   busy, done      operation in progress; one-cycle pulse on the final handshake
//   bram_rd_addr    registered read address shared by both result BRAMs
//   bram0_rd_data   result BRAM 0 read data (C0 / m)
//   bram1_rd_data   result BRAM 1 read data (C1)
//   m_valid/m_ready valid/ready output stream
//   m_data, m_last  coefficient and end-of-unload marker
module poly_bram_unloader
    import poly_bram_unloader_pkg::*;
#(
    parameter int unsigned LOGQ        = LOGQ_DEF,
    parameter int unsigned LOGN        = LOGN_DEF,
    parameter int unsigned BRAM_RD_LAT = BRAM_RD_LAT_DEF,
    // Must be at least BRAM_RD_LAT + 2 to sustain one word per cycle.
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            both,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] bram_rd_addr,
    input  logic [LOGQ-1:0] bram0_rd_data,
    input  logic [LOGQ-1:0] bram1_rd_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [LOGQ-1:0] m_data,
    output logic            m_last
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;

    unload_state_e   state_q, state_d;
    logic            both_q, both_d;
    logic [LOGN:0]   issue_cnt_q, issue_cnt_d;
    logic [LOGN:0]   accept_cnt_q, accept_cnt_d;
    logic [LOGN-1:0] addr_q, addr_d;
    logic [CntW-1:0] inflight_q, inflight_d;

    logic [LOGN:0]   total_m1;
    logic            issue;
    logic            handshake;
    logic [OccW-1:0] occupancy;
    logic [OccW-1:0] limit;
    rd_tag_t         tag_in, tag_out;
    logic            fifo_empty, fifo_full;
    logic [CntW-1:0] fifo_count;
    logic [LOGQ-1:0] capture_data;

    assign total_m1  = both_q ? {(LOGN + 1){1'b1}} : {1'b0, {LOGN{1'b1}}};
    assign handshake = m_valid && m_ready;

    // Reads in flight plus buffered words may not exceed the FIFO depth. A word
    // leaving this cycle frees its slot early so a full loop runs without bubbles.
    assign occupancy = OccW'(inflight_q) + OccW'(fifo_count);
    assign limit     = OccW'(FIFO_DEPTH) + OccW'(handshake);
    assign issue     = (state_q == StIssue) && (occupancy < limit);

    assign tag_in = '{valid: issue, sel: issue_cnt_q[LOGN], last: (issue_cnt_q == total_m1)};

    // One stage covers the address register, the rest the BRAM read latency, so the
    // tag emerges in the same cycle as the matching rd_data.
    DelayRegisterReset #(
        .WIDTH ($bits(rd_tag_t)),
        .DEPTH (BRAM_RD_LAT + 1)
    ) u_tag_pipe (
        .clk (clk),
        .rst (rst),
        .d_i (tag_in),
        .q_o (tag_out)
    );

    assign capture_data = tag_out.sel ? bram1_rd_data : bram0_rd_data;

    unload_sync_fifo #(
        .WIDTH (LOGQ + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tag_out.valid),
        .wdata_i ({tag_out.last, capture_data}),
        .pop_i   (handshake),
        .rdata_o ({m_last, m_data}),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign m_valid      = !fifo_empty;
    assign bram_rd_addr = addr_q;
    assign busy         = (state_q != StIdle);
    assign done         = handshake && busy && (accept_cnt_q == total_m1);

    always_comb begin
        state_d      = state_q;
        both_d       = both_q;
        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        addr_d       = addr_q;
        inflight_d   = inflight_q;

        case ({issue, tag_out.valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        if (handshake) begin
            accept_cnt_d = accept_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StIssue;
                    both_d       = both;
                    issue_cnt_d  = '0;
                    accept_cnt_d = '0;
                end
            end
            StIssue: begin
                if (issue) begin
                    addr_d      = issue_cnt_q[LOGN-1:0];
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == total_m1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            both_q       <= 1'b0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            addr_q       <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            both_q       <= both_d;
            issue_cnt_q  <= issue_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            addr_q       <= addr_d;
            inflight_q   <= inflight_d;
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_poly_bram_unloader.sv
module tb_poly_bram_unloader;

    localparam int unsigned LOGQ  = 54;
    localparam int unsigned LOGN  = 13;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int          N     = 1 << LOGN;

    logic            clk;
    logic            rst;
    logic            start;
    logic            both;
    logic            busy;
    logic            done;
    logic [LOGN-1:0] bram_rd_addr;
    logic [LOGQ-1:0] bram0_rd_data;
    logic [LOGQ-1:0] bram1_rd_data;
    logic            m_valid;
    logic            m_ready;
    logic [LOGQ-1:0] m_data;
    logic            m_last;

    poly_bram_unloader #(
        .LOGQ        (LOGQ),
        .LOGN        (LOGN),
        .BRAM_RD_LAT (LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .both          (both),
        .busy          (busy),
        .done          (done),
        .bram_rd_addr  (bram_rd_addr),
        .bram0_rd_data (bram0_rd_data),
        .bram1_rd_data (bram1_rd_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result BRAM model: two clock edges from address to data.
    logic [LOGN-1:0] bram_a1;
    always @(posedge clk) begin
        bram_a1       <= bram_rd_addr;
        bram0_rd_data <= LOGQ'(3 * int'(bram_a1) + 1);
        bram1_rd_data <= LOGQ'(int'(bram_a1) + 100000);
    end

    logic [LOGQ:0]   sb[$];
    int              checks = 0;
    int              errors = 0;
    int              since_start;
    int              accepted;
    int              first_valid;
    int              ready_low_pct = 0;
    int              stall_left = 0;
    bit              done_seen;
    bit              prev_stall = 0;
    logic [LOGQ-1:0] prev_data;
    logic            prev_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input bit b);
        int total;
        total = b ? 2 * N : N;
        for (int i = 0; i < total; i++) begin
            int a;
            logic [LOGQ-1:0] d;
            a = i % N;
            d = (i >= N) ? LOGQ'(a + 100000) : LOGQ'(3 * a + 1);
            sb.push_back({(i == total - 1), d});
        end
    endtask

    // One cycle: drive m_ready at the falling edge, then sample and score.
    task automatic step();
        logic [LOGQ:0] e;
        @(negedge clk);
        if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
        end else if (ready_low_pct > 0) begin
            m_ready = ($urandom_range(99) >= ready_low_pct);
        end else begin
            m_ready = 1'b1;
        end
        #1;
        since_start++;
        if (m_valid && first_valid < 0) first_valid = since_start - 1;
        if (prev_stall && !rst) begin
            chk("stall_valid_held", m_valid, 1);
            chk("stall_data_held", m_data, prev_data);
            chk("stall_last_held", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
            chk("sb_nonempty_at_handshake", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("m_data", m_data, e[LOGQ-1:0]);
                chk("m_last", m_last, e[LOGQ]);
                chk("done_on_last", done, e[LOGQ]);
                accepted++;
                if (done) done_seen = 1'b1;
            end
        end else begin
            chk("done_without_handshake", done, 0);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    task automatic start_unload(input bit b);
        start = 1'b1;
        both  = b;
        push_expected(b);
        since_start = 0;
        accepted    = 0;
        first_valid = -1;
        done_seen   = 1'b0;
        step();
        start = 1'b0;
        both  = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            step();
            n++;
        end
        chk("done_within_budget", done_seen, 1);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        both    = 1'b0;
        m_ready = 1'b0;
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_addr", bram_rd_addr, 0);
        rst = 1'b0;
        step();

        // Single polynomial, full-rate drain.
        start_unload(1'b0);
        chk("busy_after_start", busy, 1);
        run_to_done(N + 100);
        chk("first_valid_latency", first_valid, LAT + 2);
        chk("single_done_cycle", since_start, N + LAT + 2);
        chk("single_word_count", accepted, N);
        chk("single_sb_empty", sb.size(), 0);
        step();
        chk("idle_after_done", busy, 0);

        // Both polynomials, full-rate drain across the address wrap.
        start_unload(1'b1);
        run_to_done(2 * N + 100);
        chk("both_done_cycle", since_start, 2 * N + LAT + 2);
        chk("both_word_count", accepted, 2 * N);
        chk("both_sb_empty", sb.size(), 0);
        step();

        // Random backpressure.
        ready_low_pct = 30;
        start_unload(1'b1);
        run_to_done(6 * N);
        chk("random_word_count", accepted, 2 * N);
        chk("random_sb_empty", sb.size(), 0);
        ready_low_pct = 0;
        step();

        // Long initial stall: the credit window fills and the address freezes.
        stall_left = 100;
        start_unload(1'b0);
        repeat (99) step();
        chk("stall_addr_frozen", bram_rd_addr, 3);
        chk("stall_m_valid", m_valid, 1);
        chk("stall_no_words", accepted, 0);
        run_to_done(N + 100);
        chk("stall_resume_rate", since_start, 100 + N);
        chk("stall_sb_empty", sb.size(), 0);
        step();

        // Reset in the middle of an unload.
        start_unload(1'b0);
        while (accepted < 1000 && since_start < 2000) step();
        chk("reached_word_1000", accepted, 1000);
        rst = 1'b1;
        step();
        chk("midreset_m_valid", m_valid, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_addr", bram_rd_addr, 0);
        rst = 1'b0;
        sb.delete();
        prev_stall = 1'b0;

        // Restart from address 0; a start pulse while busy is ignored.
        start_unload(1'b0);
        while (accepted < 500 && since_start < 1000) step();
        chk("reached_word_500", accepted, 500);
        start = 1'b1;
        both  = 1'b1;
        step();
        start = 1'b0;
        both  = 1'b0;
        run_to_done(N + 100);
        chk("restart_done_cycle", since_start, N + LAT + 2);
        chk("restart_word_count", accepted, N);
        chk("restart_sb_empty", sb.size(), 0);
        step();
        chk("restart_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
